// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INST_PACK       = 128;
    localparam int INST_INDEX_SIZE = 32;
    localparam int PACK_BYTES      = 16;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t IDLE    = 2'd0;
    localparam fetch_state_t WAIT    = 2'd1;
    localparam fetch_state_t DISCARD = 2'd2;

    typedef struct packed {
        logic [INST_INDEX_SIZE-1:0] pc;
        logic [INST_PACK-1:0]       pack;
    } fetch_entry_t;

    function automatic logic [INST_INDEX_SIZE-1:0] pack_align(
        input logic [INST_INDEX_SIZE-1:0] addr
    );
        return addr & ~INST_INDEX_SIZE'(PACK_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched packs; head entry feeds decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 entry_in,
    output fetch_entry_t                 entry_out,
    output logic [$clog2(QUEUE_DEPTH):0] count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  slots [QUEUE_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                slots[tail] <= entry_in;
                tail        <= tail + PW'(1);
            end
            if (do_pop) begin
                head <= head + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    assign entry_out = slots[head];
    assign full      = (count == CW'(QUEUE_DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, memory request FSM and pack queue to decode.
// Define FETCH_PERF_CNT_EN to add stall/redirect performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    output logic         mem_req,
    input  logic         mem_ready,
    output logic [31:0]  mem_addr,
    input  logic [127:0] mem_data,
    input  logic         mem_valid,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         dec_valid,
    input  logic         dec_ready,
    output logic [127:0] dec_pack,
    output logic [31:0]  dec_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_stall_cycles,
    output logic [31:0]  perf_redirects
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   pc_nxt;
    logic          started;
    logic          issue;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    fetch_entry_t  new_entry;
    fetch_entry_t  head;

    // started holds off the first issue until mem_addr has loaded fetch_pc
    assign issue = started && (state == IDLE) && mem_ready && !redirect
                && (count < CW'(QUEUE_DEPTH));
    assign mem_req = issue;

    assign push = (state == WAIT) && mem_valid && !redirect;
    assign pop  = dec_valid && dec_ready && !redirect;

    assign new_entry = '{pc: fetch_pc, pack: mem_data};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (issue) state_nxt = WAIT;
            WAIT: begin
                if (mem_valid) state_nxt = IDLE;
                else if (redirect) state_nxt = DISCARD;
            end
            DISCARD: if (mem_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_nxt = fetch_pc;
        if (redirect) pc_nxt = pack_align(redirect_pc);
        else if (push) pc_nxt = fetch_pc + 32'(PACK_BYTES);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= '0;
            started  <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= pc_nxt;
            mem_addr <= pc_nxt;
            started  <= 1'b1;
        end
    end

    fetch_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop),
        .flush    (redirect),
        .entry_in (new_entry),
        .entry_out(head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign dec_valid = !empty;
    assign dec_pack  = head.pack;
    assign dec_pc    = head.pc;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
        end else begin
            if (full && (state == IDLE) && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (redirect && (perf_redirects != '1)) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`else
    logic unused_full;
    assign unused_full = full;
`endif

endmodule
